// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle CPU control FSM: state codes, opcodes,
// opcode classes and datapath mux selects.
package cpu_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_NONE
    } op_class_e;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_ALU   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU   = 2'd0;
    localparam logic [1:0] WB_SEL_MEM   = 2'd1;
    localparam logic [1:0] WB_SEL_PC4   = 2'd2;
    localparam logic [1:0] WB_SEL_IMM   = 2'd3;

    localparam logic [1:0] ALU_A_RS1    = 2'd0;
    localparam logic [1:0] ALU_A_PC     = 2'd1;
    localparam logic [1:0] ALU_A_ZERO   = 2'd2;

    localparam logic       ALU_B_RS2    = 1'b0;
    localparam logic       ALU_B_IMM    = 1'b1;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode-to-class mapping; anything outside the supported
// instruction classes is reported as not legal.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CL_NONE;
        legal    = 1'b1;
        case (opcode)
            OP_R:      op_class = CL_R;
            OP_I:      op_class = CL_I;
            OP_LOAD:   op_class = CL_LOAD;
            OP_STORE:  op_class = CL_STORE;
            OP_BRANCH: op_class = CL_BRANCH;
            OP_LUI:    op_class = CL_LUI;
            OP_AUIPC:  op_class = CL_AUIPC;
            OP_JAL:    op_class = CL_JAL;
            OP_JALR:   op_class = CL_JALR;
            default:   legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and traps on illegal opcodes or memory-ack timeout.
//   state  | meaning
//   FETCH  | instruction read, wait for mem_ack
//   DECODE | latch opcode into imm_op, legality check
//   EXEC   | ALU op; branches and jumps retire here
//   MEM    | data load/store, wait for mem_ack
//   WB     | register write, PC+4, retire
//   TRAP   | all strobes off until reset
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic [6:0] imm_op,
    output logic       retire,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    state, state_next;
    logic [6:0]    dec_op;
    op_class_e     op_class;
    logic          op_legal;
    logic [CW-1:0] wait_cnt;
    logic          waiting, timeout;

    // The live opcode is only trusted during DECODE; afterwards the latched copy rules.
    assign dec_op = (state == ST_DECODE) ? opcode : imm_op;

    opcode_class_decode u_decode (
        .opcode   (dec_op),
        .op_class (op_class),
        .legal    (op_legal)
    );

    assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ack;
    assign timeout = waiting && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign state_o = state;

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  if (mem_ack) state_next = ST_DECODE;
                       else if (timeout) state_next = ST_TRAP;
            ST_DECODE: state_next = op_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (op_class)
                    CL_R, CL_I, CL_LUI, CL_AUIPC: state_next = ST_WB;
                    CL_LOAD, CL_STORE:            state_next = ST_MEM;
                    default:                      state_next = ST_FETCH;
                endcase
            end
            ST_MEM:    if (mem_ack) state_next = (op_class == CL_LOAD) ? ST_WB : ST_FETCH;
                       else if (timeout) state_next = ST_TRAP;
            ST_WB:     state_next = ST_FETCH;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            imm_op   <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) imm_op <= opcode;
            if (state == ST_DECODE && !op_legal) illegal <= 1'b1;
            if (timeout) bus_err <= 1'b1;
            wait_cnt <= (waiting && state_next == state) ? wait_cnt + CW'(1) : '0;
        end
    end

    // Strobes are gated by rst_n so an asserted reset kills them immediately.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        reg_we       = 1'b0;
        wb_sel       = WB_SEL_ALU;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = ALU_B_RS2;
        retire       = 1'b0;
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                end
                ST_EXEC: begin
                    case (op_class)
                        CL_I, CL_LOAD, CL_STORE: alu_b_sel = ALU_B_IMM;
                        CL_AUIPC: begin
                            alu_a_sel = ALU_A_PC;
                            alu_b_sel = ALU_B_IMM;
                        end
                        CL_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_src = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                            retire = 1'b1;
                        end
                        CL_JAL, CL_JALR: begin
                            reg_we    = 1'b1;
                            wb_sel    = WB_SEL_PC4;
                            pc_we     = 1'b1;
                            retire    = 1'b1;
                            pc_src    = (op_class == CL_JAL) ? PC_SRC_IMM : PC_SRC_ALU;
                            alu_b_sel = (op_class == CL_JALR) ? ALU_B_IMM : ALU_B_RS2;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (op_class == CL_STORE);
                    if (mem_ack && op_class == CL_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    case (op_class)
                        CL_LOAD: wb_sel = WB_SEL_MEM;
                        CL_LUI:  wb_sel = WB_SEL_IMM;
                        default: wb_sel = WB_SEL_ALU;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
